// File: rtl/finv_arb.sv
// Round-robin arbiter sharing one pipelined finv unit among NREQ requesters.
// Optional FINV_ARB_PERFCNT_EN adds busy_cnt / conflict_cnt counters.
module finv_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   op_a,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          finv_a,
  input  logic [31:0]          finv_s,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_data
`ifdef FINV_ARB_PERFCNT_EN
  ,
  output logic [31:0]          busy_cnt,
  output logic [31:0]          conflict_cnt
`endif
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || LATENCY < 1) begin : g_bad_cfg
    $error("finv_arb: bad NREQ/IDW/LATENCY");
  end

  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic           sel_vld;
  logic [IDW-1:0] sel_id;

  // Search from rr_ptr upward, wrapping modulo NREQ.
  always_comb begin
    logic [IDW:0] idx;
    sel_vld = 1'b0;
    sel_id  = '0;
    idx     = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(o);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!sel_vld && req[idx[IDW-1:0]]) begin
        sel_vld = 1'b1;
        sel_id  = idx[IDW-1:0];
      end
    end
    if (rst) begin
      sel_vld = 1'b0;
    end
  end

  always_comb begin
    gnt    = '0;
    finv_a = '0;
    if (sel_vld) begin
      gnt[sel_id] = 1'b1;
      finv_a      = op_a[{sel_id, 5'b0} +: 32];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (sel_vld) begin
      if (sel_id == IDW'(NREQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = sel_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  logic [LATENCY-1:0] tv_q;
  logic [IDW-1:0]     tid_q [LATENCY];

  // Tags shift in lockstep with the finv stages; no stall path.
  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tid_q[i] <= '0;
      end
    end else begin
      tv_q[0]  <= sel_vld;
      tid_q[0] <= sel_id;
      for (int i = 1; i < LATENCY; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  logic           res_valid_q;
  logic [IDW-1:0] res_id_q;
  logic [31:0]    res_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tv_q[LATENCY-1];
      if (tv_q[LATENCY-1]) begin
        res_id_q   <= tid_q[LATENCY-1];
        res_data_q <= finv_s;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

`ifdef FINV_ARB_PERFCNT_EN
  logic [31:0] busy_q;
  logic [31:0] conflict_q;
  logic        multi_req;

  assign multi_req = |(req & (req - NREQ'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      conflict_q <= '0;
    end else begin
      if (sel_vld) begin
        busy_q <= busy_q + 32'd1;
      end
      if (multi_req) begin
        conflict_q <= conflict_q + 32'd1;
      end
    end
  end

  assign busy_cnt     = busy_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_finv_arb.sv
// Randomized + directed bench for finv_arb against a queue-based model.
// finv is modelled as an exponent-flipping pipeline of LATENCY stages.
module tb_finv_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*32-1:0]  op_a;
  logic [N-1:0]     gnt;
  logic [31:0]      finv_a;
  logic [31:0]      finv_s;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic [31:0]      res_data;
`ifdef FINV_ARB_PERFCNT_EN
  logic [31:0]      busy_cnt;
  logic [31:0]      conflict_cnt;
`endif

  always #5 clk = ~clk;

  finv_arb #(.NREQ(N), .IDW(IDW), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .op_a(op_a),
    .gnt(gnt),
    .finv_a(finv_a),
    .finv_s(finv_s),
    .res_valid(res_valid),
    .res_id(res_id),
    .res_data(res_data)
`ifdef FINV_ARB_PERFCNT_EN
    ,
    .busy_cnt(busy_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [31:0] recip(input logic [31:0] a);
    logic [7:0] e;
    e = 8'd254 - a[30:23];
    return {a[31], e, a[22:0]};
  endfunction

  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= finv_a;
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign finv_s = recip(fpipe[LAT-1]);

  typedef struct {
    int          at;
    int          id;
    logic [31:0] d;
  } res_t;

  res_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ptr     = 0;
  int          last_id = 0;
  logic [31:0] last_d  = '0;
  int          g;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] rq,
                      input logic [N*32-1:0] ops, output int gid);
    logic [N-1:0] eg;
    logic [31:0]  ea;
    logic         ev;
    @(negedge clk);
    rst = r; req = rq; op_a = ops;
    #1;
    gid = -1; eg = '0; ea = '0; ev = 1'b0;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (gid < 0 && rq[i]) gid = i;
      end
    end
    if (gid >= 0) begin
      eg = N'(1) << gid;
      ea = ops[gid*32 +: 32];
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("finv_a", finv_a, ea);
    if (expq.size() > 0 && expq[0].at == cyc) begin
      ev = 1'b1;
      last_id = expq[0].id;
      last_d  = expq[0].d;
      void'(expq.pop_front());
    end
    check("res_valid", 32'(res_valid), 32'(ev));
    check("res_id", 32'(res_id), 32'(last_id));
    check("res_data", res_data, last_d);
    if (r) begin
      expq.delete();
      ptr = 0; last_id = 0; last_d = '0;
    end else if (gid >= 0) begin
      expq.push_back('{cyc + LAT + 1, gid, recip(ea)});
      ptr = (gid + 1) % N;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    int gi;
    for (int k = 0; k < n; k++) tick(1'b0, '0, '0, gi);
  endtask

  logic [31:0]     ops4 [4];
  logic [N*32-1:0] opv;
  logic [N-1:0]    pend;
  logic [31:0]     pop  [N];

  initial begin
    ops4[0] = 32'h3f800000; ops4[1] = 32'h40000000;
    ops4[2] = 32'h40800000; ops4[3] = 32'h3f000000;
    opv = {ops4[3], ops4[2], ops4[1], ops4[0]};
    rst = 1'b1; req = '0; op_a = '0;
    repeat (3) @(posedge clk);

    // reset state + single request
    tick(1'b0, 4'b0001, {96'b0, 32'h40000000}, g);
    check("t1_gnt", 32'(gnt), 32'h1);
    idle(2);
    check("t1_idle", 32'(res_valid), 32'h0);
    idle(1);
    check("t1_valid", 32'(res_valid), 32'h1);
    check("t1_id", 32'(res_id), 32'h0);
    check("t1_data", res_data, 32'h3f000000);
    idle(3);

    // round-robin wrap
    tick(1'b0, 4'b0100, opv, g);
    check("rr_2", 32'(gnt), 32'h4);
    tick(1'b0, 4'b0101, opv, g);
    check("rr_0", 32'(gnt), 32'h1);
    tick(1'b0, 4'b0100, opv, g);
    check("rr_2b", 32'(gnt), 32'h4);
    idle(5);

    // reset in flight, then sustained four-way
    tick(1'b0, 4'b0001, {96'b0, 32'h40800000}, g);
    tick(1'b1, 4'b1111, opv, g);
    check("rst_gnt", 32'(gnt), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      tick(1'b0, 4'b0000, '0, g);
      check("rst_novalid", 32'(res_valid), 32'h0);
    end
    for (int k = 0; k < 11; k++) begin
      tick(1'b0, (k < 8) ? 4'b1111 : 4'b0000, opv, g);
      if (k < 8) check("all_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k >= 3) begin
        check("all_valid", 32'(res_valid), 32'h1);
        check("all_id", 32'(res_id), 32'((k - 3) % 4));
        check("all_data", res_data, recip(ops4[(k - 3) % 4]));
      end
    end
    idle(4);

    // idle gaps: accepts at 0, 2, 5
    for (int c = 0; c < 10; c++) begin
      logic [31:0] o;
      o = (c == 0) ? 32'h40000000 : (c == 2) ? 32'h40800000 : 32'h3f800000;
      tick(1'b0, (c == 0 || c == 2 || c == 5) ? 4'b0001 : 4'b0000,
           {96'b0, o}, g);
      check("gap_valid", 32'(res_valid), 32'(c == 3 || c == 5 || c == 8));
      if (c >= 3) begin
        check("gap_data", res_data,
              (c < 5) ? 32'h3f000000 : (c < 8) ? 32'h3e800000 : 32'h3f800000);
      end
    end
    idle(4);

    // randomized: requesters hold until granted
    pend = '0;
    for (int i = 0; i < N; i++) pop[i] = '0;
    for (int k = 0; k < 400; k++) begin
      logic r;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3) == 0) begin
          pend[i] = 1'b1;
          pop[i]  = $urandom;
        end
      end
      opv = {pop[3], pop[2], pop[1], pop[0]};
      r = (($urandom % 97) == 0);
      tick(r, pend, opv, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(5);

`ifdef FINV_ARB_PERFCNT_EN
    tick(1'b1, '0, '0, g);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0011, '0, g);
    end
    idle(1);
    check("busy_cnt", busy_cnt, 32'd10);
    check("conflict_cnt", conflict_cnt, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
